load_store_unit: RTL and testbench

Sits between the core's memory stage and the word-addressed data memory.
- Converts byte-addressed RV32I loads and stores (LB/LH/LW/LBU/LHU/SB/SH/SW) into whole-word memory accesses.
- Sub-word loads: performs lane extraction and sign or zero extension.
- Sub-word stores: performs read-modify-write, because the data memory supports only full-word writes.
- Misaligned or illegal requests are flagged as faults and never touch memory.

---
 rtl/lsu_pkg.sv | 18 +
 rtl/lsu_byte_lane.sv | 57 +++++
 rtl/load_store_unit.sv | 134 +++++++++++++
 tb/tb_load_store_unit.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lsu_pkg.sv
// Shared funct3 codes and FSM state encoding for the load/store unit.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    IDLE,
    ACCESS,
    MERGE,
    RESP,
    FAULT
  } lsu_state_t;

endpackage

// File: rtl/lsu_byte_lane.sv
// Combinational byte-lane logic: load extraction/extension, store merge and
// legality check for one RV32I load or store.
module lsu_byte_lane
  import lsu_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic        write,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] mem_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word,
  output logic        illegal
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  always_comb begin
    lane_b = mem_word[{addr_lo, 3'b000} +: 8];
    lane_h = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];

    load_data = mem_word;
    case (funct3)
      F3_B:    load_data = {{24{lane_b[7]}}, lane_b};
      F3_BU:   load_data = {24'h000000, lane_b};
      F3_H:    load_data = {{16{lane_h[15]}}, lane_h};
      F3_HU:   load_data = {16'h0000, lane_h};
      default: load_data = mem_word;
    endcase

    // Sub-word stores keep the untouched lanes of the word read from memory.
    merged_word = wdata;
    case (funct3)
      F3_B: begin
        merged_word = mem_word;
        merged_word[{addr_lo, 3'b000} +: 8] = wdata[7:0];
      end
      F3_H: begin
        merged_word = mem_word;
        merged_word[{addr_lo[1], 4'b0000} +: 16] = wdata[15:0];
      end
      default: merged_word = wdata;
    endcase

    illegal = 1'b1;
    case (funct3)
      F3_B:    illegal = 1'b0;
      F3_H:    illegal = addr_lo[0];
      F3_W:    illegal = (addr_lo != 2'b00);
      F3_BU:   illegal = write;
      F3_HU:   illegal = write | addr_lo[0];
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed RV32I load/store front end for a word-only data memory;
// sub-word stores are done as read-modify-write.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30
) (
  input  logic                     clk,
  input  logic                     rst,
  // Request handshake: a request transfers on a clock edge where req_valid
  // and req_ready are both 1. The requester holds all req_* fields steady
  // until then. Responses are a single-cycle resp_valid pulse with no ready.
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [2:0]               req_funct3,
  input  logic [31:0]              req_addr,
  input  logic [DATA_WIDTH-1:0]    req_wdata,
  output logic                     resp_valid,
  output logic [DATA_WIDTH-1:0]    resp_rdata,
  output logic                     resp_fault,
  output logic [ADDRESS_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0]    mem_write_data,
  output logic                     mem_write_enable,
  input  logic [DATA_WIDTH-1:0]    mem_read_data
);

  lsu_state_t            state;
  logic                  write_q;
  logic [2:0]            funct3_q;
  logic [31:0]           addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic                  we_q;

  logic [2:0]            lane_funct3;
  logic                  lane_write;
  logic [1:0]            lane_addr_lo;
  logic [31:0]           lane_load;
  logic [31:0]           lane_merged;
  logic                  lane_illegal;

  // In IDLE the lane logic judges the incoming request; afterwards it works
  // on the latched one.
  assign lane_funct3  = (state == IDLE) ? req_funct3    : funct3_q;
  assign lane_write   = (state == IDLE) ? req_write     : write_q;
  assign lane_addr_lo = (state == IDLE) ? req_addr[1:0] : addr_q[1:0];

  lsu_byte_lane u_byte_lane (
    .funct3      (lane_funct3),
    .write       (lane_write),
    .addr_lo     (lane_addr_lo),
    .mem_word    (mem_read_data),
    .wdata       (wdata_q),
    .load_data   (lane_load),
    .merged_word (lane_merged),
    .illegal     (lane_illegal)
  );

  assign mem_address      = addr_q[ADDRESS_WIDTH+1:2];
  assign mem_write_enable = we_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      req_ready      <= 1'b1;
      resp_valid     <= 1'b0;
      resp_rdata     <= '0;
      resp_fault     <= 1'b0;
      we_q           <= 1'b0;
      mem_write_data <= '0;
      write_q        <= 1'b0;
      funct3_q       <= 3'b000;
      addr_q         <= '0;
      wdata_q        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            write_q   <= req_write;
            funct3_q  <= req_funct3;
            addr_q    <= req_addr;
            wdata_q   <= req_wdata;
            req_ready <= 1'b0;
            if (lane_illegal) begin
              state      <= FAULT;
              resp_valid <= 1'b1;
              resp_fault <= 1'b1;
            end else begin
              state <= ACCESS;
              if (req_write && req_funct3 == F3_W) begin
                we_q           <= 1'b1;
                mem_write_data <= req_wdata;
              end
            end
          end
        end
        ACCESS: begin
          we_q <= 1'b0;
          if (!write_q) begin
            resp_rdata <= lane_load;
            resp_valid <= 1'b1;
            state      <= RESP;
          end else if (funct3_q == F3_W) begin
            resp_valid <= 1'b1;
            state      <= RESP;
          end else begin
            we_q           <= 1'b1;
            mem_write_data <= lane_merged;
            state          <= MERGE;
          end
        end
        MERGE: begin
          we_q       <= 1'b0;
          resp_valid <= 1'b1;
          state      <= RESP;
        end
        RESP, FAULT: begin
          resp_valid <= 1'b0;
          resp_fault <= 1'b0;
          resp_rdata <= '0;
          req_ready  <= 1'b1;
          state      <= IDLE;
        end
        default: begin
          we_q      <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: byte-array reference model, per-cycle
// compare process and literal checks of the documented examples.
module tb_load_store_unit;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_fault;
  logic [29:0] mem_address;
  logic [31:0] mem_write_data;
  logic        mem_write_enable;
  logic [31:0] mem_read_data;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  load_store_unit #(.DATA_WIDTH(32), .ADDRESS_WIDTH(30)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid        (req_valid),
    .req_ready        (req_ready),
    .req_write        (req_write),
    .req_funct3       (req_funct3),
    .req_addr         (req_addr),
    .req_wdata        (req_wdata),
    .resp_valid       (resp_valid),
    .resp_rdata       (resp_rdata),
    .resp_fault       (resp_fault),
    .mem_address      (mem_address),
    .mem_write_data   (mem_write_data),
    .mem_write_enable (mem_write_enable),
    .mem_read_data    (mem_read_data)
  );

  // Data memory seen by the DUT
  logic [31:0] mem [0:255];
  assign mem_read_data = mem[mem_address[7:0]];
  always @(posedge clk) if (mem_write_enable) mem[mem_address[7:0]] <= mem_write_data;

  // ---------------- reference model (byte-addressed) ----------------
  logic [7:0] ref_bytes [0:1023];

  int checks = 0;
  int passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b100: return 1;
      3'b001, 3'b101: return 2;
      3'b010:         return 4;
      default:        return 0;
    endcase
  endfunction

  function automatic bit model_illegal(input bit wr, input logic [2:0] f3, input logic [31:0] addr);
    int n = size_of(f3);
    if (n == 0) return 1'b1;
    if (wr && f3[2]) return 1'b1;
    return (int'(addr[1:0]) % n) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr);
    int n = size_of(f3);
    logic [31:0] v = 32'h0;
    logic [31:0] mask;
    for (int b = 0; b < n; b++) v = v | (32'(ref_bytes[int'(addr[9:0]) + b]) << (8 * b));
    mask = 32'((64'd1 << (8 * n)) - 64'd1);
    if (!f3[2] && n < 4 && v[8 * n - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic model_store(input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wd);
    int n = size_of(f3);
    for (int b = 0; b < n; b++) ref_bytes[int'(addr[9:0]) + b] = wd[8 * b +: 8];
  endtask

  function automatic logic [31:0] ref_word(input logic [31:0] addr);
    int base = int'(addr[9:0]) & ~3;
    return {ref_bytes[base + 3], ref_bytes[base + 2], ref_bytes[base + 1], ref_bytes[base]};
  endfunction

  // ---------------- scoreboard / compare process ----------------
  logic [31:0] exp_q[$];
  bit          pend_active = 1'b0;
  bit          skip_cmp = 1'b0;
  int          pend_k, pend_lat, pend_wr;
  bit          pend_fault;
  logic [31:0] pend_addr, pend_wdata;
  logic [31:0] last_rdata = 32'h0;
  logic        last_fault = 1'b0;

  always @(negedge clk) begin
    if (!rst && !skip_cmp) begin
      if (pend_active) begin
        pend_k++;
        check("resp_valid", 32'(resp_valid), 32'(pend_k == pend_lat));
        check("req_ready", 32'(req_ready), 32'(pend_k > pend_lat));
        check("mem_we", 32'(mem_write_enable), 32'(pend_k == pend_wr));
        if (pend_k == pend_wr) begin
          check("mem_wdata", mem_write_data, pend_wdata);
          check("mem_waddr", 32'(mem_address), pend_addr >> 2);
        end
        if (!pend_fault && pend_k <= pend_lat)
          check("mem_address", 32'(mem_address), pend_addr >> 2);
        if (pend_k == pend_lat) begin
          if (exp_q.size() == 0) begin
            checks++;
            $display("FAIL resp_unexpected: got response, expected none");
          end else begin
            check("resp_rdata", resp_rdata, exp_q.pop_front());
          end
          check("resp_fault", 32'(resp_fault), 32'(pend_fault));
          last_rdata = resp_rdata;
          last_fault = resp_fault;
        end else begin
          check("rdata_idle", resp_rdata, 32'h0);
          check("fault_idle", 32'(resp_fault), 32'h0);
        end
        if (pend_k > pend_lat) pend_active = 1'b0;
      end else begin
        check("idle_ready", 32'(req_ready), 32'h1);
        check("idle_valid", 32'(resp_valid), 32'h0);
        check("idle_we", 32'(mem_write_enable), 32'h0);
        check("idle_rdata", resp_rdata, 32'h0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_drain();
    int guard = 0;
    while (pend_active && guard < 50) begin
      @(posedge clk);
      guard++;
    end
    if (pend_active) begin
      checks++;
      $display("FAIL drain_timeout: request still pending after %0d cycles", guard);
      pend_active = 1'b0;
    end
  endtask

  task automatic do_req(input bit wr, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd);
    bit ill;
    logic [31:0] exp_rd;
    wait_drain();
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wd;
    ill = model_illegal(wr, f3, addr);
    pend_fault = ill;
    pend_addr  = addr;
    pend_lat   = ill ? 1 : ((wr && f3 != F3_W) ? 3 : 2);
    pend_wr    = (ill || !wr) ? -1 : ((f3 == F3_W) ? 1 : 2);
    exp_rd     = (ill || wr) ? 32'h0 : model_load(f3, addr);
    if (!ill && wr) begin
      model_store(f3, addr, wd);
      pend_wdata = ref_word(addr);
    end
    exp_q.push_back(exp_rd);
    @(posedge clk); #1;
    req_valid = 1'b0;
    pend_k = 0;
    pend_active = 1'b1;
    wait_drain();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int i = 0; i < 256; i++) begin
      logic [31:0] w;
      w = (i == 64) ? 32'h8899AABB : (32'(i) * 32'h01010101) ^ 32'hA5C33C5A;
      mem[i] = w;
      for (int b = 0; b < 4; b++) ref_bytes[4 * i + b] = w[8 * b +: 8];
    end

    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 32'(req_ready), 32'h1);
    check("rst_valid", 32'(resp_valid), 32'h0);
    check("rst_rdata", resp_rdata, 32'h0);
    check("rst_fault", 32'(resp_fault), 32'h0);
    check("rst_we", 32'(mem_write_enable), 32'h0);
    check("rst_wdata", mem_write_data, 32'h0);
    check("rst_addr", 32'(mem_address), 32'h0);
    rst = 1'b0;

    // Pin the model against hand-computed values
    check("model_lb", model_load(F3_B, 32'h101), 32'hFFFFFFAA);
    check("model_lhu", model_load(F3_HU, 32'h102), 32'h00008899);
    check("model_ill_lw", 32'(model_illegal(1'b0, F3_W, 32'h102)), 32'h1);

    do_req(1'b0, F3_B,  32'h101, 32'h0); check("lit_lb",  last_rdata, 32'hFFFFFFAA);
    do_req(1'b0, F3_BU, 32'h101, 32'h0); check("lit_lbu", last_rdata, 32'h000000AA);
    do_req(1'b0, F3_H,  32'h102, 32'h0); check("lit_lh",  last_rdata, 32'hFFFF8899);
    do_req(1'b0, F3_HU, 32'h102, 32'h0); check("lit_lhu", last_rdata, 32'h00008899);
    do_req(1'b0, F3_W,  32'h100, 32'h0); check("lit_lw",  last_rdata, 32'h8899AABB);

    do_req(1'b1, F3_B, 32'h103, 32'h12345677);
    check("lit_sb_mem", mem[64], 32'h7799AABB);
    do_req(1'b0, F3_W, 32'h100, 32'h0); check("lit_lw_after_sb", last_rdata, 32'h7799AABB);

    do_req(1'b1, F3_W, 32'h104, 32'hDEADBEEF);
    check("lit_sw_mem", mem[65], 32'hDEADBEEF);
    check("lit_sw_rdata", last_rdata, 32'h0);

    do_req(1'b0, F3_W, 32'h102, 32'h0);      check("lit_fault_lw", 32'(last_fault), 32'h1);
    do_req(1'b1, F3_H, 32'h101, 32'h5555);   check("lit_fault_sh", 32'(last_fault), 32'h1);
    do_req(1'b0, 3'b011, 32'h100, 32'h0);    check("lit_fault_f3", 32'(last_fault), 32'h1);
    do_req(1'b1, F3_BU, 32'h100, 32'h11);    check("lit_fault_sbu", 32'(last_fault), 32'h1);
    do_req(1'b0, 3'b111, 32'h100, 32'h0);

    do_req(1'b1, F3_H, 32'h102, 32'hCAFE1234);
    do_req(1'b0, F3_H, 32'h102, 32'h0);      check("lit_lh_pos", last_rdata, 32'h00001234);
    do_req(1'b1, F3_B, 32'h100, 32'h00000080);
    do_req(1'b0, F3_B, 32'h100, 32'h0);      check("lit_lb_neg", last_rdata, 32'hFFFFFF80);
    do_req(1'b0, F3_W, 32'h100, 32'h0);      check("lit_lw_merged", last_rdata, 32'h1234AA80);
    do_req(1'b1, F3_H, 32'h10E, 32'h0000F00D);
    do_req(1'b0, F3_HU, 32'h10E, 32'h0);     check("lit_lhu_hi", last_rdata, 32'h0000F00D);

    // Reset during the write cycle of a halfword store
    skip_cmp = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = F3_H; req_addr = 32'h100; req_wdata = 32'h0000BEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    check("rr_access_valid", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    check("rr_merge_we", 32'(mem_write_enable), 32'h1);
    rst = 1'b1;
    #1;
    check("rr_we_gated", 32'(mem_write_enable), 32'h0);
    check("rr_no_valid", 32'(resp_valid), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rr_ready", 32'(req_ready), 32'h1);
    check("rr_valid_after", 32'(resp_valid), 32'h0);
    check("rr_mem_kept", mem[64], ref_word(32'h100));
    skip_cmp = 1'b0;

    do_req(1'b0, F3_W, 32'h100, 32'h0);      check("lit_lw_after_rst", last_rdata, 32'h1234AA80);
    do_req(1'b0, F3_W, 32'h104, 32'h0);      check("lit_lw_sw", last_rdata, 32'hDEADBEEF);

    for (int i = 0; i < 256; i++) check("final_mem", mem[i], ref_word(32'(4 * i)));
    check("exp_q_empty", 32'(exp_q.size()), 32'h0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
